// File: rtl/sm2201_camac_cycle_controller.sv
// rtl/sm2201_camac_cycle_controller.sv - SM2201 ISA-to-CAMAC dataway cycle controller (option macro: CAMAC_AUTOINC_EN)
module sm2201_camac_cycle_controller #(
  parameter logic [9:0] BASE_ADDR = 10'h300,
  parameter int         T_SETUP   = 2,
  parameter int         T_S1      = 3,
  parameter int         T_GAP     = 1,
  parameter int         T_S2      = 3,
  parameter int         MAX_WAIT  = 120
) (
  input  logic        isa_clk,
  input  logic        isa_reset,
  input  logic [9:0]  isa_addr,
  input  logic        isa_aen,
  input  logic        isa_ior,
  input  logic        isa_iow,
  input  logic [7:0]  isa_data_in,
  output logic [7:0]  isa_data_out,
  output logic        isa_data_oe,
  output logic        isa_chrdy,
  output logic        isa_irq,
  output logic [4:0]  camac_n,
  output logic [3:0]  camac_a,
  output logic [4:0]  camac_f,
  output logic [23:0] camac_wdata,
  input  logic [23:0] camac_rdata,
  input  logic        camac_x,
  input  logic        camac_q,
  input  logic        camac_lam,
  output logic        camac_b,
  output logic        camac_s1,
  output logic        camac_s2
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [7:0] SETUP_LAST = 8'(T_SETUP - 1);
  localparam logic [7:0] S1_LAST    = 8'(T_S1 - 1);
  localparam logic [7:0] GAP_LAST   = 8'(T_GAP - 1);
  localparam logic [7:0] S2_LAST    = 8'(T_S2 - 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_S1, ST_GAP, ST_S2, ST_RELEASE
  } state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic        sel;
  logic [2:0]  off;
  logic        busy;

  logic        iow_q, ior_q;
  logic        wr_sel, rd_sel, wr_go;
  logic [2:0]  wr_off, rd_off;
  logic [7:0]  wr_data;

  logic [7:0]  wd0, wd1, wd2;
  logic [4:0]  n_reg;
  logic [3:0]  a_reg;
  logic        irq_en;
  logic        x_reg, q_reg;
  logic [23:0] rdata_reg;

  logic        lam_s1, lam_s2, lam_s3;
  logic        lam_pending, lam_pend_nxt, irq_en_nxt;
  logic        timeout, overrun;
  logic [WW-1:0] wait_cnt;
  logic        wait_cond, wait_hit;
  logic        lam_rise, rd_clr, f_wr, ctl_wr;

  assign sel  = !isa_aen && (isa_addr[9:3] == BASE_ADDR[9:3]);
  assign off  = isa_addr[2:0];
  assign busy = (state != ST_IDLE);

  assign f_wr     = wr_go && (wr_off == 3'd5);
  assign ctl_wr   = wr_go && (wr_off == 3'd6);
  assign lam_rise = lam_s2 && !lam_s3;
  assign rd_clr   = rd_sel && (rd_off == 3'd5) && !ior_q && isa_ior;

  assign wait_cond = sel && (!isa_ior || !isa_iow) && ((off <= 3'd2) || (off == 3'd5)) && busy;
  assign wait_hit  = wait_cond && (wait_cnt == WAIT_LAST);
  assign isa_chrdy = !(wait_cond && (wait_cnt != WAIT_MAX));

  assign isa_data_oe = sel && !isa_ior;
  assign camac_wdata = {wd2, wd1, wd0};

  // Read mux straight off the live ISA address
  always_comb begin
    isa_data_out = 8'h00;
    case (off)
      3'd0: isa_data_out = rdata_reg[7:0];
      3'd1: isa_data_out = rdata_reg[15:8];
      3'd2: isa_data_out = rdata_reg[23:16];
      3'd3: isa_data_out = {3'b000, n_reg};
      3'd4: isa_data_out = {4'b0000, a_reg};
      3'd5: isa_data_out = {busy, x_reg, q_reg, lam_pending, timeout, overrun, 2'b00};
      3'd6: isa_data_out = {7'b0000000, irq_en};
      default: isa_data_out = 8'h00;
    endcase
  end

  // Next LAM/irq-enable state; a new LAM edge beats a simultaneous clear
  always_comb begin
    lam_pend_nxt = lam_pending;
    irq_en_nxt   = irq_en;
    if (ctl_wr) begin
      irq_en_nxt = wr_data[0];
      if (wr_data[1]) lam_pend_nxt = 1'b0;
    end
    if (lam_rise) lam_pend_nxt = 1'b1;
  end

  // Track ISA strobes; latch address/data while a strobe is low, flag the write one cycle after iow rises
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      iow_q   <= 1'b0;
      ior_q   <= 1'b0;
      wr_sel  <= 1'b0;
      rd_sel  <= 1'b0;
      wr_off  <= 3'd0;
      rd_off  <= 3'd0;
      wr_data <= 8'h00;
      wr_go   <= 1'b0;
    end else begin
      iow_q <= isa_iow;
      ior_q <= isa_ior;
      if (!isa_iow) begin
        wr_sel  <= sel;
        wr_off  <= off;
        wr_data <= isa_data_in;
      end
      if (!isa_ior) begin
        rd_sel <= sel;
        rd_off <= off;
      end
      wr_go <= wr_sel && !iow_q && isa_iow;
    end
  end

  // Staging registers written from ISA; A optionally steps at the end of each cycle
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      wd0   <= 8'h00;
      wd1   <= 8'h00;
      wd2   <= 8'h00;
      n_reg <= 5'd0;
      a_reg <= 4'd0;
    end else begin
      if (wr_go && (wr_off == 3'd0)) wd0 <= wr_data;
      if (wr_go && (wr_off == 3'd1)) wd1 <= wr_data;
      if (wr_go && (wr_off == 3'd2)) wd2 <= wr_data;
      if (wr_go && (wr_off == 3'd3)) n_reg <= wr_data[4:0];
      if (wr_go && (wr_off == 3'd4)) a_reg <= wr_data[3:0];
`ifdef CAMAC_AUTOINC_EN
      else if (state == ST_RELEASE) a_reg <= a_reg + 4'd1;
`endif
    end
  end

  // Dataway strobe sequencer; NAF frozen at start, X/Q/R sampled on the last S1 clock
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      state     <= ST_IDLE;
      cnt       <= 8'd0;
      camac_b   <= 1'b0;
      camac_s1  <= 1'b0;
      camac_s2  <= 1'b0;
      camac_n   <= 5'd0;
      camac_a   <= 4'd0;
      camac_f   <= 5'd0;
      x_reg     <= 1'b0;
      q_reg     <= 1'b0;
      rdata_reg <= 24'h000000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (f_wr) begin
            state   <= ST_SETUP;
            cnt     <= 8'd0;
            camac_b <= 1'b1;
            camac_n <= n_reg;
            camac_a <= a_reg;
            camac_f <= wr_data[4:0];
          end
        end
        ST_SETUP: begin
          if (cnt == SETUP_LAST) begin
            state    <= ST_S1;
            cnt      <= 8'd0;
            camac_s1 <= 1'b1;
          end else cnt <= cnt + 8'd1;
        end
        ST_S1: begin
          if (cnt == S1_LAST) begin
            state    <= ST_GAP;
            cnt      <= 8'd0;
            camac_s1 <= 1'b0;
            x_reg    <= camac_x;
            q_reg    <= camac_q;
            if (camac_f < 5'd8) rdata_reg <= camac_rdata;
          end else cnt <= cnt + 8'd1;
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            state    <= ST_S2;
            cnt      <= 8'd0;
            camac_s2 <= 1'b1;
          end else cnt <= cnt + 8'd1;
        end
        ST_S2: begin
          if (cnt == S2_LAST) begin
            state    <= ST_RELEASE;
            cnt      <= 8'd0;
            camac_s2 <= 1'b0;
          end else cnt <= cnt + 8'd1;
        end
        ST_RELEASE: begin
          state   <= ST_IDLE;
          camac_b <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // LAM synchronizer, interrupt, wait-state watchdog and sticky error flags
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      lam_s1      <= 1'b0;
      lam_s2      <= 1'b0;
      lam_s3      <= 1'b0;
      lam_pending <= 1'b0;
      irq_en      <= 1'b0;
      isa_irq     <= 1'b0;
      timeout     <= 1'b0;
      overrun     <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      lam_s1      <= camac_lam;
      lam_s2      <= lam_s1;
      lam_s3      <= lam_s2;
      lam_pending <= lam_pend_nxt;
      irq_en      <= irq_en_nxt;
      isa_irq     <= irq_en_nxt && lam_pend_nxt;
      if (!wait_cond) wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
      if (wait_hit) timeout <= 1'b1;
      else if (rd_clr) timeout <= 1'b0;
      if (f_wr && busy) overrun <= 1'b1;
      else if (rd_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sm2201_camac_cycle_controller.sv
// tb/tb_sm2201_camac_cycle_controller.sv - scoreboard bench for sm2201_camac_cycle_controller
module tb_sm2201_camac_cycle_controller;

  localparam logic [9:0] BASE = 10'h300;
  localparam int T_SETUP = 2, T_S1 = 3, T_GAP = 1, T_S2 = 3, MW = 4;
  localparam int TL = T_SETUP + T_S1 + T_GAP + T_S2 + 1;

  logic        clk = 1'b0;
  logic        isa_reset = 1'b0;
  logic [9:0]  isa_addr = 10'h000;
  logic        isa_aen = 1'b0, isa_ior = 1'b1, isa_iow = 1'b1;
  logic [7:0]  isa_data_in = 8'h00;
  logic [7:0]  isa_data_out;
  logic        isa_data_oe, isa_chrdy, isa_irq;
  logic [4:0]  camac_n, camac_f;
  logic [3:0]  camac_a;
  logic [23:0] camac_wdata;
  logic [23:0] camac_rdata = 24'h000000;
  logic        camac_x = 1'b0, camac_q = 1'b0, camac_lam = 1'b0;
  logic        camac_b, camac_s1, camac_s2;

  sm2201_camac_cycle_controller #(.MAX_WAIT(MW)) dut (
    .isa_clk(clk), .isa_reset(isa_reset), .isa_addr(isa_addr), .isa_aen(isa_aen),
    .isa_ior(isa_ior), .isa_iow(isa_iow), .isa_data_in(isa_data_in),
    .isa_data_out(isa_data_out), .isa_data_oe(isa_data_oe), .isa_chrdy(isa_chrdy),
    .isa_irq(isa_irq), .camac_n(camac_n), .camac_a(camac_a), .camac_f(camac_f),
    .camac_wdata(camac_wdata), .camac_rdata(camac_rdata), .camac_x(camac_x),
    .camac_q(camac_q), .camac_lam(camac_lam), .camac_b(camac_b),
    .camac_s1(camac_s1), .camac_s2(camac_s2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  n;
    logic [3:0]  a;
    logic [4:0]  f;
    logic [23:0] wd;
    bit          aborted;
  } cyc_t;

  logic [7:0] exp_rd[$];
  int         exp_wait[$];
  cyc_t       exp_cyc[$];
  int         exp_irq[$];
  logic       take = 1'b0;

  // Reference state of the register file, derived from the access history
  logic [4:0]  m_n;
  logic [3:0]  m_a;
  logic [23:0] m_wd, m_rdata;
  logic        m_x, m_q, m_lam, m_irq_en, m_to, m_ov;

  task automatic model_reset();
    m_n = 0; m_a = 0; m_wd = 0; m_rdata = 0;
    m_x = 0; m_q = 0; m_lam = 0; m_irq_en = 0; m_to = 0; m_ov = 0;
  endtask

  function automatic logic [7:0] model_read(input int off);
    case (off)
      0: return m_rdata[7:0];
      1: return m_rdata[15:8];
      2: return m_rdata[23:16];
      3: return {3'b000, m_n};
      4: return {4'b0000, m_a};
      5: return {1'b0, m_x, m_q, m_lam, m_to, m_ov, 2'b00};
      6: return {7'b0, m_irq_en};
      default: return 8'h00;
    endcase
  endfunction

  task automatic isa_write(input logic [9:0] addr, input logic aen, input logic [7:0] d,
                           input int w, input bit raise_lam);
    bit ok = 0;
    exp_wait.push_back(w);
    @(posedge clk); #1;
    isa_addr = addr; isa_aen = aen; isa_data_in = d; isa_iow = 1'b0;
    if (raise_lam) camac_lam = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (isa_chrdy) begin ok = 1; break; end
    end
    if (!ok) chk("write_chrdy_bound", 32'd0, 32'd1);
    @(posedge clk); #1;
    isa_iow = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    isa_aen = 1'b0;
  endtask

  task automatic wr(input int off, input logic [7:0] d);
    isa_write(BASE | 10'(off), 1'b0, d, 0, 1'b0);
    case (off)
      0: m_wd[7:0] = d;
      1: m_wd[15:8] = d;
      2: m_wd[23:16] = d;
      3: m_n = d[4:0];
      4: m_a = d[3:0];
      6: begin m_irq_en = d[0]; if (d[1]) m_lam = 0; end
      default: ;
    endcase
  endtask

  task automatic rd(input int off, input int w);
    bit ok = 0;
    exp_rd.push_back(model_read(off));
    exp_wait.push_back(w);
    if (off == 5) begin m_to = 0; m_ov = 0; end
    @(posedge clk); #1;
    isa_addr = BASE | 10'(off); isa_ior = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (isa_chrdy) begin ok = 1; break; end
    end
    if (!ok) chk("read_chrdy_bound", 32'd0, 32'd1);
    @(posedge clk); #1; take = 1'b1;
    @(posedge clk); #1; take = 1'b0; isa_ior = 1'b1;
  endtask

  task automatic start_cycle(input logic [4:0] f, input bit aborted);
    cyc_t c;
    c.n = m_n; c.a = m_a; c.f = f; c.wd = m_wd; c.aborted = aborted;
    exp_cyc.push_back(c);
    isa_write(BASE | 10'd5, 1'b0, {3'b000, f}, 0, 1'b0);
    if (f < 5'd8) m_rdata = camac_rdata;
    m_x = camac_x; m_q = camac_q;
`ifdef CAMAC_AUTOINC_EN
    m_a = m_a + 4'd1;
`endif
  endtask

  task automatic wait_idle();
    repeat (TL + 2) @(posedge clk);
  endtask

  // Read-data monitor
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (take) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_rd.pop_front();
          chk("rd_data", {24'h0, isa_data_out}, {24'h0, e});
          chk("rd_oe", {31'h0, isa_data_oe}, 32'd1);
        end
      end
    end
  end

  // Wait-state monitor: counts chrdy-low clocks per ISA strobe
  initial begin
    int  wc = 0;
    bit  act = 0;
    forever begin
      @(negedge clk);
      if (!isa_ior || !isa_iow) begin
        act = 1;
        if (!isa_chrdy) wc++;
      end else if (act) begin
        if (exp_wait.size() == 0) chk("wait_unexpected", 32'd1, 32'd0);
        else chk("wait_states", wc, exp_wait.pop_front());
        wc = 0; act = 0;
      end
    end
  end

  // Dataway cycle monitor: NAF/W at B rise, strobe offsets, B length, NAF stability
  initial begin
    cyc_t c;
    bit   in_c = 0, have = 0, frozen = 1;
    int   cnt = 0, s1o = -1, s2o = -1;
    forever begin
      @(negedge clk);
      if (camac_b && !in_c) begin
        in_c = 1; cnt = 1; s1o = -1; s2o = -1; frozen = 1;
        if (exp_cyc.size() == 0) begin chk("cyc_unexpected", 32'd1, 32'd0); have = 0; end
        else begin
          c = exp_cyc.pop_front(); have = 1;
          chk("cyc_n", camac_n, c.n);
          chk("cyc_a", camac_a, c.a);
          chk("cyc_f", camac_f, c.f);
          chk("cyc_wdata", camac_wdata, c.wd);
        end
      end else if (camac_b && in_c) cnt++;
      if (in_c && camac_b) begin
        if (camac_s1 && s1o < 0) s1o = cnt - 1;
        if (camac_s2 && s2o < 0) s2o = cnt - 1;
        if (have && (camac_n != c.n || camac_a != c.a || camac_f != c.f)) frozen = 0;
      end
      if (in_c && !camac_b) begin
        in_c = 0;
        if (have) begin
          chk("cyc_s1_offset", s1o, T_SETUP);
          chk("cyc_naf_frozen", {31'h0, frozen}, 32'd1);
          if (!c.aborted) begin
            chk("cyc_b_len", cnt, TL);
            chk("cyc_s2_offset", s2o, T_SETUP + T_S1 + T_GAP);
          end
        end
      end
    end
  end

  // Interrupt monitor: each irq rise must match a scheduled one
  initial begin
    logic prev = 0;
    forever begin
      @(negedge clk);
      if (isa_irq && !prev) begin
        if (exp_irq.size() == 0) chk("irq_unexpected", 32'd1, 32'd0);
        else chk("irq_latency", cyc, exp_irq.pop_front());
      end
      prev = isa_irq;
    end
  end

  initial begin
    logic [4:0] f;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_b", camac_b, 0);
    chk("rst_s1s2", {camac_s1, camac_s2}, 0);
    chk("rst_chrdy", isa_chrdy, 1);
    chk("rst_irq", isa_irq, 0);
    chk("rst_naf", {camac_n, camac_a, camac_f}, 0);
    chk("rst_wdata", camac_wdata, 0);
    chk("rst_oe", isa_data_oe, 0);
    @(posedge clk); #1 isa_reset = 1'b1;

    // Directed write cycle
    wr(3, 8'd5); wr(4, 8'd3); wr(0, 8'hF0); wr(1, 8'hC3); wr(2, 8'hA5);
    start_cycle(5'd16, 0);
    wait_idle();
    rd(3, 0); rd(4, 0); rd(7, 0);

    // Directed read cycle
    camac_rdata = 24'h123456; camac_x = 1; camac_q = 1;
    start_cycle(5'd0, 0);
    wait_idle();
    rd(0, 0); rd(1, 0); rd(2, 0); rd(5, 0);

    // Randomized cycles
    for (int it = 0; it < 10; it++) begin
      wr(3, 8'($urandom_range(0, 31)));
      wr(4, 8'($urandom_range(0, 15)));
      wr(0, 8'($urandom)); wr(1, 8'($urandom)); wr(2, 8'($urandom));
      camac_rdata = 24'($urandom); camac_x = 1'($urandom); camac_q = 1'($urandom);
      f = 5'($urandom_range(0, 31));
      start_cycle(f, 0);
      wait_idle();
      for (int o = 0; o < 7; o++) rd(o, 0);
    end

    // N rewritten while busy: staging changes, dataway N held
    start_cycle(5'd17, 0);
    wr(3, 8'd30);
    wait_idle();
    rd(3, 0);
    start_cycle(5'd18, 0);
    wait_idle();

    // Read stalled until the cycle completes
    camac_rdata = 24'hBEEF42; camac_x = 0; camac_q = 1;
    start_cycle(5'd2, 0);
    repeat (6) @(posedge clk);
    rd(0, TL - 7);
    wait_idle();
    rd(2, 0);

    // Read stalled past the watchdog limit
    camac_rdata = 24'h0F0F0F;
    start_cycle(5'd24, 0);
    rd(1, MW);
    m_to = 1;
    wait_idle();
    rd(5, 0); rd(5, 0);

    // Start write while busy: watchdog releases it, start is dropped
    start_cycle(5'd0, 0);
    isa_write(BASE | 10'd5, 1'b0, 8'h01, MW, 1'b0);
    m_to = 1; m_ov = 1;
    wait_idle();
    rd(5, 0); rd(5, 0);

    // A after two back-to-back cycles from 15
    wr(4, 8'd15);
    start_cycle(5'd0, 0); wait_idle(); rd(4, 0);
    start_cycle(5'd0, 0); wait_idle(); rd(4, 0);

    // Accesses outside the decoded window are ignored
    isa_write(BASE | 10'd3, 1'b1, 8'h1F, 0, 1'b0);
    isa_write(10'h308 | 10'd3, 1'b0, 8'h1E, 0, 1'b0);
    rd(3, 0);

    // LAM -> irq
    wr(6, 8'h01);
    @(posedge clk); #1 camac_lam = 1'b1;
    exp_irq.push_back(cyc + 3);
    m_lam = 1;
    repeat (5) @(posedge clk);
    #1 camac_lam = 1'b0;
    repeat (4) @(posedge clk);
    rd(5, 0);
    isa_write(BASE | 10'd6, 1'b0, 8'h03, 0, 1'b1);
    repeat (4) @(posedge clk);
    #1 camac_lam = 1'b0;
    rd(5, 0); rd(6, 0);
    repeat (4) @(posedge clk);
    wr(6, 8'h03);
    rd(5, 0);
    wr(6, 8'h00);
    @(posedge clk); #1 camac_lam = 1'b1;
    m_lam = 1;
    repeat (5) @(posedge clk);
    #1 camac_lam = 1'b0;
    rd(5, 0);
    wr(6, 8'h02);
    rd(5, 0);

    // Reset asserted while S1 is high
    start_cycle(5'd16, 1);
    repeat (3) @(posedge clk);
    #2 isa_reset = 1'b0;
    #1;
    chk("midrst_b", camac_b, 0);
    chk("midrst_s1s2", {camac_s1, camac_s2}, 0);
    chk("midrst_chrdy", isa_chrdy, 1);
    @(posedge clk); @(posedge clk); #1 isa_reset = 1'b1;
    model_reset();
    rd(5, 0); rd(3, 0);

    repeat (20) @(posedge clk);
    chk("left_rd", exp_rd.size(), 0);
    chk("left_wait", exp_wait.size(), 0);
    chk("left_cyc", exp_cyc.size(), 0);
    chk("left_irq", exp_irq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
